// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target register interface
// Contents: target FSM state encoding, byte width, default emulated-sensor address.
package i2c_pkg;

  localparam int          I2C_BYTE_BITS = 8;
  localparam logic [2:0]  LAST_BIT      = 3'(I2C_BYTE_BITS - 1);
  localparam logic [6:0]  MPU9150_ADDR  = 7'h68;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_target_regif_if.sv
// rtl/i2c_target_regif_if.sv - byte-wide register-file access port
// Signals:
//   reg_addr  register pointer            (target -> register file)
//   reg_wdata write byte                  (target -> register file)
//   reg_we    one-clk write strobe        (target -> register file)
//   reg_re    one-clk read request        (target -> register file)
//   reg_rdata read byte, one clk after re (register file -> target)
interface i2c_target_regif_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  // master: the I2C target issuing accesses; slave: the register file
  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, glitch filter and edge flags for one I2C line
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   din         raw bus line
//   level       filtered level (resets to 1, the idle bus level)
//   rise, fall  one-clk flags, asserted in the same clk the filtered level changes
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      // cnt counts consecutive synchronized samples that disagree with level;
      // any agreeing sample restarts the run, so short glitches never flip it.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_target_regif.sv
// rtl/i2c_target_regif.sv - I2C target that maps bus transfers onto a register-file port
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   scl, sda_in bus lines as seen at the pins (no clock stretching)
//   sda_oe      1 = pull SDA low
//   busy        high while this target is addressed
//   regs        register-file port (pointer, write strobe/data, read request/data)
module i2c_target_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = MPU9150_ADDR,
  parameter int         FILTER_LEN = 4,
  parameter int         ADDR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 busy,
  i2c_target_regif_if.master   regs
);
  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .din(scl),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .din(sda_in),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        tx;
  logic [7:0]        rdata_q;
  logic              rw;
  logic              ack_on;   // ACK states: ACK driven; READ_ACK: master ACKed
  logic              re_d;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;

  logic       start_cond, stop_cond;
  logic [7:0] rx_byte;

  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;
  assign rx_byte    = {shift[6:0], sda_f};

  assign regs.reg_addr  = reg_addr;
  assign regs.reg_wdata = reg_wdata;
  assign regs.reg_we    = reg_we;
  assign regs.reg_re    = reg_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      rdata_q   <= '0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      re_d      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      // reg_rdata is valid in the clk after reg_re, so capture one clk later
      re_d   <= reg_re;
      if (re_d) rdata_q <= regs.reg_rdata;

      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_cond) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR, PTR, WRITE: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                ack_on <= 1'b0;
                if (state == ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    rw     <= rx_byte[0];
                    busy   <= 1'b1;
                    reg_re <= rx_byte[0];
                    state  <= ADDR_ACK;
                  end else begin
                    state <= IDLE;
                  end
                end else if (state == PTR) begin
                  reg_addr <= ADDR_W'(rx_byte);
                  state    <= PTR_ACK;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  state     <= WRITE_ACK;
                end
              end
            end
          end

          // First scl_fall drives the ACK, the second one ends the ACK slot.
          ADDR_ACK, PTR_ACK, WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  sda_oe <= ~rdata_q[7];
                  tx     <= {rdata_q[6:0], 1'b0};
                  state  <= READ;
                end else begin
                  sda_oe <= 1'b0;
                  if (state == ADDR_ACK) begin
                    state <= PTR;
                  end else begin
                    if (state == WRITE_ACK) reg_addr <= reg_addr + ADDR_W'(1);
                    state <= WRITE;
                  end
                end
              end
            end
          end

          // bit7 is already on the bus on entry; each fall shifts the next bit
          // out, and the fall ending bit0 releases SDA for the master's ACK.
          READ: begin
            if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                state  <= READ_ACK;
              end else begin
                sda_oe  <= ~tx[7];
                tx      <= {tx[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          READ_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                ack_on   <= 1'b1;
                reg_addr <= reg_addr + ADDR_W'(1);
                reg_re   <= 1'b1;
              end else begin
                // NACK: stay busy until the master issues STOP or START
                sda_oe <= 1'b0;
                state  <= IDLE;
              end
            end else if (scl_fall && ack_on) begin
              sda_oe  <= ~rdata_q[7];
              tx      <= {rdata_q[6:0], 1'b0};
              bit_cnt <= '0;
              state   <= READ;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
